// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - Memory-side responder with programmable wait states and idle-time preload port.
// Serves one latched read or write per transaction and answers it with a one-cycle mem_ready.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                op_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Preload and the deferred transaction write share the single array write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    if (state_q == IDLE && load_en) begin
      mem_we    = 1'b1;
      mem_waddr = load_addr;
      mem_wdata = load_data;
    end else if (state_q == WAIT && cnt_q == 4'd0 && op_write_q) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array: contents survive reset, and reset blocks any pending write.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_en) begin
            state_q <= IDLE;
          end else if (mem_read && mem_write) begin
            err_q <= 1'b1;
          end else if (mem_read || mem_write) begin
            op_write_q <= mem_write;
            addr_q     <= addr;
            wdata_q    <= wdata;
            cnt_q      <= WAIT_CNT;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!op_write_q) begin
              rdata_q <= mem_q[addr_q];
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_ready = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - Bench for mem_responder with two instances (WAIT_CYCLES 2 and 0).
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int OP_RD = 0, OP_WR = 1, OP_LD = 2, OP_ILL = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_read  [2];
  logic       mem_write [2];
  logic [7:0] addr      [2];
  logic [7:0] wdata     [2];
  logic [7:0] rdata     [2];
  logic       mem_ready [2];
  logic       busy      [2];
  logic       err       [2];
  logic       load_en   [2];
  logic [7:0] load_addr [2];
  logic [7:0] load_data [2];

  int tests = 0;
  int fails = 0;

  logic [7:0] mdl    [2][256];
  logic [7:0] mdl_rd [2];
  int         wcs    [2] = '{2, 0};

  typedef struct {
    int         op;
    logic [7:0] a;
    logic [7:0] dat;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl [10];

  always #5 clock = ~clock;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .mem_ready(mem_ready[0]), .busy(busy[0]), .err(err[0]),
    .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0])
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(reset),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .mem_ready(mem_ready[1]), .busy(busy[1]), .err(err[1]),
    .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input int d, input int op, input logic [7:0] a, input logic [7:0] dat);
    int   n;
    bit   got;
    bit   busy_ok;
    @(negedge clock);
    case (op)
      OP_LD: begin
        load_en[d] = 1'b1; load_addr[d] = a; load_data[d] = dat;
        @(negedge clock);
        load_en[d] = 1'b0;
        mdl[d][a] = dat;
      end
      OP_ILL: begin
        mem_read[d] = 1'b1; mem_write[d] = 1'b1; addr[d] = a; wdata[d] = dat;
        @(negedge clock);
        chk("err_pulse", err[d], 1);
        chk("err_busy", busy[d], 0);
        mem_read[d] = 1'b0; mem_write[d] = 1'b0;
        @(negedge clock);
        chk("err_one_cycle", err[d], 0);
        chk("err_rdata", rdata[d], mdl_rd[d]);
      end
      default: begin
        mem_read[d] = (op == OP_RD); mem_write[d] = (op == OP_WR);
        addr[d] = a; wdata[d] = dat;
        n = 0; got = 0; busy_ok = 1;
        while (!got && n < 40) begin
          @(negedge clock);
          n++;
          if (busy[d] !== 1'b1) busy_ok = 0;
          if (mem_ready[d] === 1'b1) got = 1;
        end
        mem_read[d] = 1'b0; mem_write[d] = 1'b0;
        chk("latency", n, wcs[d] + 2);
        chk("busy_during", busy_ok, 1);
        if (op == OP_RD) mdl_rd[d] = mdl[d][a];
        else mdl[d][a] = dat;
        chk(op == OP_RD ? "read_data" : "rdata_kept_on_write", rdata[d], mdl_rd[d]);
        @(negedge clock);
        chk("ready_one_cycle", mem_ready[d], 0);
        chk("idle_after_resp", busy[d], 0);
      end
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         n;
    int         np;
    int         pcyc [4];
    logic [7:0] nv;
    for (int d = 0; d < 2; d++) begin
      mem_read[d] = 0; mem_write[d] = 0; addr[d] = 0; wdata[d] = 0;
      load_en[d] = 0; load_addr[d] = 0; load_data[d] = 0; mdl_rd[d] = 0;
    end
    tbl[0] = '{OP_LD,  8'h10, 8'hA5, 8'h00};
    tbl[1] = '{OP_RD,  8'h10, 8'h00, 8'hA5};
    tbl[2] = '{OP_WR,  8'h3C, 8'h5A, 8'hA5};
    tbl[3] = '{OP_RD,  8'h3C, 8'h00, 8'h5A};
    tbl[4] = '{OP_ILL, 8'h3C, 8'h77, 8'h5A};
    tbl[5] = '{OP_RD,  8'h3C, 8'h00, 8'h5A};
    tbl[6] = '{OP_LD,  8'hFF, 8'hC3, 8'h5A};
    tbl[7] = '{OP_RD,  8'hFF, 8'h00, 8'hC3};
    tbl[8] = '{OP_WR,  8'h00, 8'h01, 8'hC3};
    tbl[9] = '{OP_RD,  8'h00, 8'h00, 8'h01};

    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rdata", rdata[d], 0);
      chk("reset_ready", mem_ready[d], 0);
      chk("reset_busy", busy[d], 0);
      chk("reset_err", err[d], 0);
    end
    reset = 1'b0;

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++)
        do_op(d, OP_LD, 8'(a), 8'($urandom));

    for (int i = 0; i < 10; i++) begin
      do_op(0, tbl[i].op, tbl[i].a, tbl[i].dat);
      chk("table_rdata", rdata[0], tbl[i].exp_rd);
    end

    // Reset during the WAIT of a write must abort it.
    do_op(0, OP_LD, 8'h20, 8'h11);
    @(negedge clock);
    mem_write[0] = 1; addr[0] = 8'h20; wdata[0] = 8'hFF;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_ready", mem_ready[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_rdata_w0", rdata[1], 0);
    mdl_rd[0] = 0; mdl_rd[1] = 0;
    mem_write[0] = 0;
    @(negedge clock);
    reset = 1'b0;
    do_op(0, OP_RD, 8'h20, 8'h00);
    chk("aborted_write", rdata[0], 8'h11);

    // Preload and read together: request deferred one cycle, sees the new data.
    nv = ~mdl[0][8'h55];
    @(negedge clock);
    load_en[0] = 1; load_addr[0] = 8'h55; load_data[0] = nv;
    mem_read[0] = 1; addr[0] = 8'h55;
    mdl[0][8'h55] = nv;
    n = 0;
    while (mem_ready[0] !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
      load_en[0] = 0;
    end
    mem_read[0] = 0;
    mdl_rd[0] = nv;
    chk("load_defer_latency", n, 5);
    chk("load_defer_data", rdata[0], nv);
    @(negedge clock);

    // Back-to-back held reads with zero wait states, switching to the top address.
    do_op(1, OP_LD, 8'hFF, 8'hC3);
    do_op(1, OP_LD, 8'h00, 8'h3C);
    @(negedge clock);
    mem_read[1] = 1; addr[1] = 8'h00;
    np = 0; n = 0;
    while (np < 4 && n < 30) begin
      @(negedge clock);
      n++;
      if (mem_ready[1] === 1'b1) begin
        pcyc[np] = n;
        chk("b2b_data", rdata[1], np < 2 ? 8'h3C : 8'hC3);
        np++;
        if (np == 2) addr[1] = 8'hFF;
      end
    end
    mem_read[1] = 0;
    mdl_rd[1] = 8'hC3;
    chk("b2b_count", np, 4);
    for (int k = 0; k < 4; k++) chk("b2b_spacing", pcyc[k], 2 + 3 * k);
    @(negedge clock);

    for (int i = 0; i < 60; i++)
      do_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        nv = 8'($urandom);
        do_op(d, OP_RD, nv, 8'h00);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
